// File: rtl/hamming_frame_encoder.sv
// Serial Hamming(7,4)/SECDED(8,4) frame encoder: collects K data bits, encodes, interleaves,
// prepends a sync word and serialises MSB-first on tx_tick, with ping-pong buffering.
module hamming_frame_encoder #(
  parameter int unsigned       N_BLOCKS  = 8,
  parameter int unsigned       SECDED    = 0,
  parameter int unsigned       SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'h7E
) (
  input  logic                                        clk_in,
  input  logic                                        rst,
  input  logic                                        in_bit,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        tx_tick,
  input  logic                                        inj_en,
  input  logic [SYNC_W+N_BLOCKS*(7+SECDED)-1:0]       err_mask,
  output logic                                        out_bit,
  output logic                                        out_valid,
  output logic                                        out_sof,
  output logic [15:0]                                 frame_cnt
);

  localparam int unsigned CW_W    = 7 + SECDED;
  localparam int unsigned K       = 4 * N_BLOCKS;
  localparam int unsigned P_W     = N_BLOCKS * CW_W;
  localparam int unsigned FRAME_W = SYNC_W + P_W;
  localparam int unsigned CNT_W   = $clog2(K);
  localparam int unsigned REM_W   = $clog2(FRAME_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;  // index 0 on the wire, shift register already free

  logic [K-1:0]       col_q, col_d, shift_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               col_full_q, col_full_d;
  logic [K-1:0]       hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               in_ready_d;
  logic [1:0]         st_q, st_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               out_bit_d, out_valid_d, out_sof_d;
  logic [15:0]        frame_cnt_d;
  logic               accept_c, last_c, load_c;
  logic [P_W-1:0]     enc_c;
  logic [FRAME_W-1:0] frame_c;

  // Per-nibble Hamming encode, scattered straight into interleaved payload positions
  for (genvar j = 0; j < N_BLOCKS; j++) begin : g_blk
    logic [3:0]      n;
    logic [CW_W-1:0] cw;
    assign n       = hold_q[4*j +: 4];
    assign cw[6:0] = {n[3], n[2], n[1], n[1]^n[2]^n[3], n[0], n[0]^n[2]^n[3], n[0]^n[1]^n[3]};
    if (SECDED != 0) begin : g_secded
      assign cw[CW_W-1] = ^cw[6:0];
    end
    for (genvar b = 0; b < CW_W; b++) begin : g_bit
      assign enc_c[b*N_BLOCKS + j] = cw[b];
    end
  end

  assign frame_c = {SYNC_WORD, enc_c} ^ (inj_en ? err_mask : '0);

  always_comb begin
    col_d       = col_q;
    cnt_d       = cnt_q;
    col_full_d  = col_full_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    st_d        = st_q;
    sr_d        = sr_q;
    rem_d       = rem_q;
    out_bit_d   = out_bit;
    out_valid_d = out_valid;
    out_sof_d   = out_sof;
    frame_cnt_d = frame_cnt;

    accept_c = in_valid && in_ready;
    last_c   = (st_q == ST_SEND) && tx_tick && (rem_q == REM_W'(1));
    load_c   = hold_full_q && ((st_q != ST_SEND) || last_c);
    shift_c  = {col_q[K-2:0], in_bit};

    // Holding register: drains into TX, refills from a parked full collector
    if (load_c) hold_full_d = 1'b0;
    if (col_full_q && (!hold_full_q || load_c)) begin
      hold_d      = col_q;
      hold_full_d = 1'b1;
      col_full_d  = 1'b0;
    end

    if (accept_c) begin
      col_d = shift_c;
      if (col_full_q) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q == CNT_W'(K - 1)) begin
        cnt_d = '0;
        if (!hold_full_q || load_c) begin
          hold_d      = shift_c;
          hold_full_d = 1'b1;
        end else begin
          col_full_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    in_ready_d = !(hold_full_d && col_full_d);

    case (st_q)
      ST_IDLE: ;
      ST_SEND: begin
        if (tx_tick) begin
          out_bit_d   = sr_q[FRAME_W-1];
          out_valid_d = 1'b1;
          out_sof_d   = (rem_q == REM_W'(FRAME_W));
          sr_d        = {sr_q[FRAME_W-2:0], 1'b0};
          rem_d       = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) st_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tx_tick) begin
          out_bit_d   = 1'b0;
          out_valid_d = 1'b0;
          out_sof_d   = 1'b0;
          st_d        = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase

    if (load_c) begin
      sr_d        = frame_c;
      rem_d       = REM_W'(FRAME_W);
      st_d        = ST_SEND;
      frame_cnt_d = frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      cnt_q       <= '0;
      col_full_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      in_ready    <= 1'b1;
      st_q        <= ST_IDLE;
      sr_q        <= '0;
      rem_q       <= '0;
      out_bit     <= 1'b0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      col_full_q  <= col_full_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      in_ready    <= in_ready_d;
      st_q        <= st_d;
      sr_q        <= sr_d;
      rem_q       <= rem_d;
      out_bit     <= out_bit_d;
      out_valid   <= out_valid_d;
      out_sof     <= out_sof_d;
      frame_cnt   <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_hamming_frame_encoder.sv
// Bench for hamming_frame_encoder: a Hamming(7,4) instance and a SECDED instance share one input stream
// and their serial outputs are reassembled into frames and compared against a positional Hamming model.
module tb_hamming_frame_encoder;

  localparam int unsigned FW_A = 64;
  localparam int unsigned FW_B = 72;

  logic        clk_in = 1'b0;
  logic        rst, in_bit, in_valid, tx_tick, inj_en;
  logic [71:0] mask;
  logic        rdy_a, ob_a, ov_a, sof_a, rdy_b, ob_b, ov_b, sof_b;
  logic [15:0] fc_a, fc_b;

  int          checks = 0;
  int          passes = 0;
  int          nframes = 0;
  int          tick_per = 1;
  int          cyc = 0;
  bit          saw_bp = 1'b0;
  int          pos_a = 0, pos_b = 0;
  logic [71:0] acc_a = '0, acc_b = '0;
  logic [71:0] exp_a[$], exp_b[$], got_a[$], got_b[$];

  hamming_frame_encoder dut_a (
    .clk_in(clk_in), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(rdy_a),
    .tx_tick(tx_tick), .inj_en(inj_en), .err_mask(mask[FW_A-1:0]),
    .out_bit(ob_a), .out_valid(ov_a), .out_sof(sof_a), .frame_cnt(fc_a));

  hamming_frame_encoder #(.SECDED(1)) dut_b (
    .clk_in(clk_in), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(rdy_b),
    .tx_tick(tx_tick), .inj_en(inj_en), .err_mask(mask),
    .out_bit(ob_b), .out_valid(ov_b), .out_sof(sof_b), .frame_cnt(fc_b));

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference frame: textbook positional Hamming (parity at positions 1,2,4), then block interleave
  function automatic logic [71:0] model(input logic [31:0] w, input int secded);
    logic [71:0] f;
    logic [7:0]  c;
    logic [3:0]  nib;
    bit          par;
    int          cw_w;
    cw_w = 7 + secded;
    f = '0;
    for (int j = 0; j < 8; j++) begin
      nib = w[4*j +: 4];
      c = '0;
      c[2] = nib[0]; c[4] = nib[1]; c[5] = nib[2]; c[6] = nib[3];
      for (int p = 0; p < 3; p++) begin
        par = 1'b0;
        for (int pos = 1; pos <= 7; pos++)
          if (((pos >> p) & 1) == 1 && (pos & (pos - 1)) != 0) par ^= c[pos-1];
        c[(1 << p) - 1] = par;
      end
      if (secded != 0) c[7] = ^c[6:0];
      for (int b = 0; b < cw_w; b++) f[b*8 + j] = c[b];
    end
    f[8*cw_w +: 8] = 8'h7E;
    return f;
  endfunction

  initial begin
    tx_tick = 1'b0;
    forever begin
      @(negedge clk_in);
      cyc++;
      tx_tick = (cyc % tick_per) == 0;
    end
  end

  always @(posedge clk_in) begin
    if (!rst && (rdy_a === 1'b0)) saw_bp = 1'b1;
    if (!rst && tx_tick) begin
      #1;
      if (ov_a) begin
        check("sof_a", 72'(sof_a), 72'(pos_a == 0));
        acc_a = {acc_a[70:0], ob_a};
        pos_a++;
        if (pos_a == FW_A) begin got_a.push_back(72'(acc_a[FW_A-1:0])); pos_a = 0; end
      end
    end
  end

  always @(posedge clk_in) begin
    if (!rst && tx_tick) begin
      #1;
      if (ov_b) begin
        check("sof_b", 72'(sof_b), 72'(pos_b == 0));
        acc_b = {acc_b[70:0], ob_b};
        pos_b++;
        if (pos_b == FW_B) begin got_b.push_back(acc_b); pos_b = 0; end
      end
    end
  end

  task automatic send(input logic [31:0] w, input int nbits);
    int guard;
    for (int i = 31; i > 31 - nbits; i--) begin
      guard = 0;
      @(negedge clk_in);
      while (!(rdy_a && rdy_b) && guard < 2000) begin
        in_valid = 1'b0;
        @(negedge clk_in);
        guard++;
      end
      if (guard >= 2000) check("send_timeout", 72'(guard), 72'd0);
      in_valid = 1'b1;
      in_bit   = w[i];
    end
  endtask

  task automatic push(input logic [31:0] w);
    exp_a.push_back(model(w, 0) ^ (inj_en ? 72'(mask[FW_A-1:0]) : 72'd0));
    exp_b.push_back(model(w, 1) ^ (inj_en ? mask : 72'd0));
    nframes++;
  endtask

  task automatic push_lit(input logic [31:0] w, input logic [71:0] lit_a);
    exp_a.push_back(lit_a);
    exp_b.push_back(model(w, 1) ^ (inj_en ? mask : 72'd0));
    nframes++;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    @(negedge clk_in);
    in_valid = 1'b0;
    while ((got_a.size() < exp_a.size() || got_b.size() < exp_b.size()) && guard < 20000) begin
      @(negedge clk_in);
      guard++;
    end
    repeat (6) @(negedge clk_in);
    check({tag, "_count_a"}, 72'(got_a.size()), 72'(exp_a.size()));
    check({tag, "_count_b"}, 72'(got_b.size()), 72'(exp_b.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) check({tag, "_frame_a"}, got_a[i], exp_a[i]);
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) check({tag, "_frame_b"}, got_b[i], exp_b[i]);
    check({tag, "_frame_cnt_a"}, 72'(fc_a), 72'(nframes[15:0]));
    check({tag, "_frame_cnt_b"}, 72'(fc_b), 72'(nframes[15:0]));
    exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready_a"},  72'(rdy_a), 72'd1);
    check({tag, "_out_bit_a"},   72'(ob_a),  72'd0);
    check({tag, "_out_valid_a"}, 72'(ov_a),  72'd0);
    check({tag, "_out_sof_a"},   72'(sof_a), 72'd0);
    check({tag, "_frame_cnt_a"}, 72'(fc_a),  72'd0);
    check({tag, "_in_ready_b"},  72'(rdy_b), 72'd1);
    check({tag, "_out_valid_b"}, 72'(ov_b),  72'd0);
    check({tag, "_frame_cnt_b"}, 72'(fc_b),  72'd0);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; inj_en = 1'b0; mask = '0;
    repeat (3) @(negedge clk_in);
    reset_checks("reset");
    rst = 1'b0;

    // Single-bit word, tick every cycle
    tick_per = 1;
    send(32'h0000_0001, 32);
    push_lit(32'h0000_0001, 72'h00_7E00_0000_0001_0101);
    drain("one");

    // All-ones then all-zeros back to back
    send(32'hFFFF_FFFF, 32);
    push_lit(32'hFFFF_FFFF, 72'h00_7EFF_FFFF_FFFF_FFFF);
    send(32'h0000_0000, 32);
    push_lit(32'h0000_0000, 72'h00_7E00_0000_0000_0000);
    drain("ones_zeros");

    // Slow channel forces back-pressure; frames must arrive intact
    tick_per = 4;
    saw_bp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = $urandom();
      send(w, 32);
      push(w);
    end
    drain("bp");
    check("bp_seen", 72'(saw_bp), 72'd1);

    // Error injection on fixed bit positions
    tick_per = 1;
    inj_en = 1'b1;
    mask = '0;
    mask[54] = 1'b1; mask[53] = 1'b1; mask[36] = 1'b1; mask[27] = 1'b1;
    send(32'h0000_0000, 32);
    push_lit(32'h0000_0000, 72'h00_7E60_0010_0800_0000);
    drain("inj");
    inj_en = 1'b0;

    // Random words, mixed tick rates
    tick_per = $urandom_range(1, 3);
    for (int i = 0; i < 6; i++) begin
      w = $urandom();
      send(w, 32);
      push(w);
    end
    drain("rand");

    for (int i = 0; i < 3; i++) begin
      tick_per = $urandom_range(1, 2);
      inj_en = 1'b1;
      mask = 72'({$urandom(), $urandom(), $urandom()});
      w = $urandom();
      send(w, 32);
      push(w);
      drain("rand_inj");
    end
    inj_en = 1'b0;

    // Reset while sending with a partial word collected
    tick_per = 1;
    send($urandom(), 32);
    send($urandom(), 17);
    repeat (5) @(negedge clk_in);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk_in);
    pos_a = 0; pos_b = 0;
    exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
    nframes = 0;
    reset_checks("midrst");
    rst = 1'b0;
    w = $urandom();
    send(w, 32);
    push(w);
    drain("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
